// File: rtl/battleship_pkg.sv
// Shared constants, fleet-word layout and FSM encoding for the shot
// resolution and piece-counting stages.
package battleship_pkg;

    localparam int NUM_ENTRADAS = 12;
    localparam int ADDR_W       = 5;
    localparam int DATA_W       = 64;
    localparam int SLOTS        = 5;
    localparam int COORD_W      = 8;
    localparam int MAX_COORD    = 10;

    // Cell field inside a fleet word: SLOTS slots of COORD_W bits
    localparam int FIELD_LSB    = 3;
    localparam int FIELD_MSB    = 42;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CMP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } estado_t;

    // A coordinate is legal when both row and column lie in 1..MAX_COORD
    function automatic logic coord_valida(input logic [3:0] l, input logic [3:0] c);
        return (l != 4'd0) && (l <= 4'(MAX_COORD)) &&
               (c != 4'd0) && (c <= 4'(MAX_COORD));
    endfunction

endpackage

// File: rtl/processa_disparo_compara_slots.sv
// Combinational slot matcher: finds the lowest slot equal to the shot
// coordinate, returns the word with that slot zeroed and whether the
// remaining cell field is empty.
module compara_slots
    import battleship_pkg::*;
(
    input  logic [DATA_W-1:0]  palavra,
    input  logic [COORD_W-1:0] coord,
    output logic               achou,
    output logic [DATA_W-1:0]  palavra_limpa,
    output logic               vazio
);

    logic [2:0] indice_s;

    // Priority search: scanning downward lets the lowest matching slot win
    always_comb begin
        achou    = 1'b0;
        indice_s = 3'd0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (palavra[FIELD_LSB + COORD_W*i +: COORD_W] == coord) begin
                achou    = 1'b1;
                indice_s = 3'(i);
            end else begin
                achou    = achou;
                indice_s = indice_s;
            end
        end
    end

    // Zero only the selected slot; header bits pass through untouched
    always_comb begin
        palavra_limpa = palavra;
        for (int i = 0; i < SLOTS; i++) begin
            if (achou && (indice_s == 3'(i))) begin
                palavra_limpa[FIELD_LSB + COORD_W*i +: COORD_W] = {COORD_W{1'b0}};
            end else begin
                palavra_limpa = palavra_limpa;
            end
        end
        vazio = (palavra_limpa[FIELD_MSB:FIELD_LSB] == {(FIELD_MSB-FIELD_LSB+1){1'b0}});
    end

endmodule

// File: rtl/processa_disparo.sv
// Shot resolver: scans the target fleet memory entry by entry, clears the
// hit cell with a single write-back and reports hit / sunk / miss / error.
module processa_disparo
    import battleship_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              jogador_alvo,
    input  logic [3:0]        linha,
    input  logic [3:0]        coluna,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] addr,
    output logic              mem_sel,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              acerto,
    output logic              afundou,
    output logic              erro
);

    estado_t             estado_r, estado_prox_s;
    logic [3:0]          linha_r, linha_prox_s;
    logic [3:0]          coluna_r, coluna_prox_s;
    logic                sel_r, sel_prox_s;
    logic [ADDR_W-1:0]   addr_r, addr_prox_s;
    logic                we_r, we_prox_s;
    logic [DATA_W-1:0]   wdata_r, wdata_prox_s;
    logic                busy_r, busy_prox_s;
    logic                done_r, done_prox_s;
    logic                acerto_r, acerto_prox_s;
    logic                afundou_r, afundou_prox_s;
    logic                erro_r, erro_prox_s;

    logic                achou_s;
    logic [DATA_W-1:0]   limpa_s;
    logic                vazio_s;

    compara_slots u_compara (
        .palavra       (mem_rdata),
        .coord         ({linha_r, coluna_r}),
        .achou         (achou_s),
        .palavra_limpa (limpa_s),
        .vazio         (vazio_s)
    );

    // Next-state and next-output logic; every output is registered below
    always_comb begin
        estado_prox_s  = estado_r;
        linha_prox_s   = linha_r;
        coluna_prox_s  = coluna_r;
        sel_prox_s     = sel_r;
        addr_prox_s    = addr_r;
        we_prox_s      = 1'b0;
        wdata_prox_s   = wdata_r;
        busy_prox_s    = busy_r;
        done_prox_s    = 1'b0;
        acerto_prox_s  = acerto_r;
        afundou_prox_s = afundou_r;
        erro_prox_s    = erro_r;

        case (estado_r)
            ST_IDLE: begin
                if (start) begin
                    linha_prox_s   = linha;
                    coluna_prox_s  = coluna;
                    sel_prox_s     = jogador_alvo;
                    addr_prox_s    = {ADDR_W{1'b0}};
                    acerto_prox_s  = 1'b0;
                    afundou_prox_s = 1'b0;
                    busy_prox_s    = 1'b1;
                    if (!coord_valida(linha, coluna)) begin
                        erro_prox_s   = 1'b1;
                        done_prox_s   = 1'b1;
                        estado_prox_s = ST_DONE;
                    end else begin
                        erro_prox_s   = 1'b0;
                        estado_prox_s = ST_RD;
                    end
                end else begin
                    busy_prox_s = 1'b0;
                end
            end
            ST_RD: begin
                estado_prox_s = ST_CMP;
            end
            ST_CMP: begin
                if (achou_s) begin
                    we_prox_s      = 1'b1;
                    wdata_prox_s   = limpa_s;
                    acerto_prox_s  = 1'b1;
                    afundou_prox_s = vazio_s;
                    estado_prox_s  = ST_WR;
                end else if (addr_r == ADDR_W'(NUM_ENTRADAS - 1)) begin
                    acerto_prox_s  = 1'b0;
                    done_prox_s    = 1'b1;
                    estado_prox_s  = ST_DONE;
                end else begin
                    addr_prox_s    = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    estado_prox_s  = ST_RD;
                end
            end
            ST_WR: begin
                done_prox_s   = 1'b1;
                estado_prox_s = ST_DONE;
            end
            ST_DONE: begin
                busy_prox_s   = 1'b0;
                estado_prox_s = ST_IDLE;
            end
            default: begin
                busy_prox_s   = 1'b0;
                estado_prox_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r <= ST_IDLE;
        end else begin
            estado_r <= estado_prox_s;
        end
    end

    // Latched shot, memory interface and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            linha_r   <= 4'd0;
            coluna_r  <= 4'd0;
            sel_r     <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            we_r      <= 1'b0;
            wdata_r   <= {DATA_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            acerto_r  <= 1'b0;
            afundou_r <= 1'b0;
            erro_r    <= 1'b0;
        end else begin
            linha_r   <= linha_prox_s;
            coluna_r  <= coluna_prox_s;
            sel_r     <= sel_prox_s;
            addr_r    <= addr_prox_s;
            we_r      <= we_prox_s;
            wdata_r   <= wdata_prox_s;
            busy_r    <= busy_prox_s;
            done_r    <= done_prox_s;
            acerto_r  <= acerto_prox_s;
            afundou_r <= afundou_prox_s;
            erro_r    <= erro_prox_s;
        end
    end

    assign addr      = addr_r;
    assign mem_sel   = sel_r;
    assign mem_we    = we_r;
    assign mem_wdata = wdata_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign acerto    = acerto_r;
    assign afundou   = afundou_r;
    assign erro      = erro_r;

endmodule

// File: tb/tb_processa_disparo.sv
// Scoreboard bench for processa_disparo: a reference fleet model predicts
// each shot's write-back and result; a negedge monitor compares them.
module tb_processa_disparo;
    import battleship_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              jogador_alvo = 1'b0;
    logic [3:0]        linha = 4'd0;
    logic [3:0]        coluna = 4'd0;
    logic [63:0]       mem_rdata = 64'd0;
    logic [4:0]        addr;
    logic              mem_sel, mem_we, busy, done, acerto, afundou, erro;
    logic [63:0]       mem_wdata;

    typedef struct { int cyc; logic acerto; logic afundou; logic erro; int max_addr; } res_t;
    typedef struct { int cyc; logic [4:0] addr; logic sel; logic [63:0] data; } wr_t;

    res_t        res_q[$];
    wr_t         wr_q[$];
    logic [63:0] m1[0:11], m2[0:11];   // memories seen by the DUT
    logic [63:0] r1[0:11], r2[0:11];   // reference model
    int          total = 0, bad = 0;
    int          cyc = 0, t0 = 0, maxa = 0;
    bit          done_seen = 0;

    processa_disparo dut (
        .clk(clk), .rst_n(rst_n), .start(start), .jogador_alvo(jogador_alvo),
        .linha(linha), .coluna(coluna), .mem_rdata(mem_rdata), .addr(addr),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_wdata(mem_wdata), .busy(busy),
        .done(done), .acerto(acerto), .afundou(afundou), .erro(erro)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read fleet memories, written by the DUT strobe
    always @(posedge clk) begin
        if (addr < 5'd12) mem_rdata <= mem_sel ? m2[addr] : m1[addr];
        else              mem_rdata <= 64'd0;
        if (mem_we && addr < 5'd12) begin
            if (mem_sel) m2[addr] <= mem_wdata;
            else         m1[addr] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [20:0] hi, input logic [7:0] s4, s3, s2, s1, s0,
                                       input logic [2:0] lo);
        return {hi, s4, s3, s2, s1, s0, lo};
    endfunction

    // Reference model: first slot match in entry order, lowest slot first
    task automatic predict(input logic sel, input logic [3:0] l, input logic [3:0] c, input bit commit);
        res_t r; wr_t w; logic [63:0] word; bit hit;
        hit = 0;
        r.erro = (l == 4'd0) || (l > 4'd10) || (c == 4'd0) || (c > 4'd10);
        r.acerto = 1'b0; r.afundou = 1'b0;
        if (r.erro) begin
            r.cyc = 1; r.max_addr = 0;
        end else begin
            r.cyc = 25; r.max_addr = 11;
            for (int e = 0; e < 12 && !hit; e++) begin
                word = sel ? r2[e] : r1[e];
                for (int s = 0; s < 5 && !hit; s++) begin
                    if (word[3+8*s +: 8] == {l, c}) begin
                        hit = 1;
                        word[3+8*s +: 8] = 8'h00;
                        r.acerto = 1'b1;
                        r.afundou = (word[42:3] == 40'd0);
                        r.cyc = 2*e + 4; r.max_addr = e;
                        w.cyc = 2*e + 3; w.addr = 5'(e); w.sel = sel; w.data = word;
                        wr_q.push_back(w);
                        if (commit) begin
                            if (sel) r2[e] = word; else r1[e] = word;
                        end
                    end
                end
            end
        end
        res_q.push_back(r);
    endtask

    // Monitor: compares write-backs and results against the scoreboard
    always @(negedge clk) begin
        res_t r; wr_t w;
        if (rst_n) begin
            if (busy) begin
                if (int'(addr) > maxa) maxa = int'(addr);
                chk("addr_range", {63'd0, addr <= 5'd11}, 64'd1);
            end
            if (mem_we) begin
                if (wr_q.size() == 0) chk("we_unexpected", 64'd1, 64'd0);
                else begin
                    w = wr_q.pop_front();
                    chk("we_cycle", 64'(cyc - t0), 64'(w.cyc));
                    chk("we_addr", {59'd0, addr}, {59'd0, w.addr});
                    chk("we_sel", {63'd0, mem_sel}, {63'd0, w.sel});
                    chk("we_data", mem_wdata, w.data);
                end
            end
            if (done) begin
                done_seen = 1;
                if (res_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
                else begin
                    r = res_q.pop_front();
                    chk("done_cycle", 64'(cyc - t0), 64'(r.cyc));
                    chk("acerto", {63'd0, acerto}, {63'd0, r.acerto});
                    chk("afundou", {63'd0, afundou}, {63'd0, r.afundou});
                    chk("erro", {63'd0, erro}, {63'd0, r.erro});
                    chk("busy_done", {63'd0, busy}, 64'd1);
                    chk("max_addr", 64'(maxa), 64'(r.max_addr));
                    chk("wq_empty", 64'(wr_q.size()), 64'd0);
                end
            end
        end
    end

    task automatic shoot(input logic sel, input logic [3:0] l, input logic [3:0] c,
                         input int glitch_at, input bit rst_in_wr);
        bit stop;
        stop = 0;
        @(negedge clk);
        predict(sel, l, c, !rst_in_wr);
        maxa = 0; done_seen = 0;
        jogador_alvo = sel; linha = l; coluna = c; start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0; jogador_alvo = ~sel; linha = ~l; coluna = ~c;
        for (int n = 1; n < 40 && !done_seen && !stop; n++) begin
            if (glitch_at == n) begin
                chk("busy_mid", {63'd0, busy}, 64'd1);
                start = 1'b1; jogador_alvo = ~sel; linha = 4'd5; coluna = 4'd6;
            end else begin
                start = 1'b0;
            end
            if (rst_in_wr && mem_we) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_we", {63'd0, mem_we}, 64'd0);
                chk("rst_busy", {63'd0, busy}, 64'd0);
                chk("rst_done", {63'd0, done}, 64'd0);
                res_q.delete(); wr_q.delete();
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                stop = 1;
            end else begin
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!done_seen && !stop) chk("timeout", 64'd0, 64'd1);
    endtask

    function automatic int sunk(input bit p2, input bit dut_side);
        int k; logic [63:0] w;
        k = 0;
        for (int e = 0; e < 12; e++) begin
            w = dut_side ? (p2 ? m2[e] : m1[e]) : (p2 ? r2[e] : r1[e]);
            if (w[42:3] == 40'd0) k++;
        end
        return k;
    endfunction

    initial begin
        for (int e = 0; e < 12; e++) begin
            m1[e] = mk(21'(e), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'(e));
            m2[e] = mk(21'(e + 100), 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3'(e + 1));
        end
        m1[0]  = mk(21'h1ABCD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 3'b110);
        m1[1]  = mk(21'h00000, 8'h00, 8'h00, 8'h24, 8'h23, 8'h22, 3'b000);
        m1[7]  = mk(21'h15555, 8'h00, 8'h00, 8'h00, 8'h99, 8'h98, 3'b001);
        m1[11] = mk(21'h00003, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3A, 3'b010);
        m2[3]  = mk(21'h0F0F0, 8'h00, 8'h00, 8'h57, 8'h58, 8'h56, 3'b011);
        m2[5]  = mk(21'h12345, 8'h00, 8'h66, 8'h71, 8'h66, 8'h72, 3'b100);
        m2[11] = mk(21'h00000, 8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 3'b111);
        for (int e = 0; e < 12; e++) begin r1[e] = m1[e]; r2[e] = m2[e]; end

        repeat (2) @(negedge clk);
        chk("rst_addr", {59'd0, addr}, 64'd0);
        chk("rst_outs", {57'd0, mem_sel, mem_we, busy, done, acerto, afundou, erro}, 64'd0);
        chk("rst_wdata", mem_wdata, 64'd0);
        rst_n = 1'b1;

        shoot(1'b1, 4'd5,  4'd7,  0, 0);   // P2 entry 3 slot 2
        shoot(1'b0, 4'd1,  4'd1,  0, 0);   // P1 entry 0 sinks
        shoot(1'b0, 4'd10, 4'd10, 0, 0);   // full-scan miss
        shoot(1'b0, 4'd0,  4'd4,  0, 0);   // illegal row 0
        shoot(1'b0, 4'd11, 4'd2,  0, 0);   // illegal row 11
        shoot(1'b1, 4'd4,  4'd11, 0, 0);   // illegal column 11
        shoot(1'b1, 4'd4,  4'd5,  5, 0);   // last entry, start pulsed while busy
        shoot(1'b1, 4'd6,  4'd6,  0, 0);   // duplicate slots, lowest cleared
        shoot(1'b0, 4'd9,  4'd9,  0, 1);   // reset during WR
        shoot(1'b0, 4'd9,  4'd9,  0, 0);   // same shot accepted after reset
        shoot(1'b0, 4'd2,  4'd2,  0, 0);   // hit
        shoot(1'b0, 4'd2,  4'd2,  0, 0);   // repeat: miss, no write
        shoot(1'b0, 4'd3,  4'd10, 0, 0);   // entry 11 sinks

        repeat (3) @(negedge clk);
        for (int e = 0; e < 12; e++) begin
            chk($sformatf("mem1_%0d", e), m1[e], r1[e]);
            chk($sformatf("mem2_%0d", e), m2[e], r2[e]);
        end
        chk("sunk_p1", 64'(sunk(0, 1)), 64'(sunk(0, 0)));
        chk("sunk_p2", 64'(sunk(1, 1)), 64'(sunk(1, 0)));
        chk("sunk_p1_abs", 64'(sunk(0, 1)), 64'd10);
        chk("left_res", 64'(res_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/processa_disparo.md
Name: processa_disparo

Overview:
- Resolves one shot against the targeted player's fleet memory.
- Sits directly upstream of the piece-counting stage.
- Scans the 12 fleet entries for the fired coordinate, clears the matching cell slot and writes the entry back, then reports hit/sunk/miss.
- The counter later reads the updated memory, where an entry whose 40-bit cell field is all zero counts as a sunk vessel.

Parameters:
- NUM_ENTRADAS, 12, fleet entries per player (addresses 0..NUM_ENTRADAS-1).
- ADDR_W, 5, memory address width.
- DATA_W, 64, memory word width.
- SLOTS, 5, cell slots per entry.
- COORD_W, 8, slot width: [7:4] linha, [3:0] coluna.
- MAX_COORD, 10, largest legal linha/coluna value (legal range 1..10).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle shot request; sampled only in IDLE.
- jogador_alvo  in  1  target fleet: 0 = P1 memory, 1 = P2 memory; latched at start.
- linha  in  4  shot row; latched at start.
- coluna  in  4  shot column; latched at start.
- mem_rdata  in  DATA_W  read data from selected memory, valid the cycle after addr is presented.
- addr  out  ADDR_W  memory address.
- mem_sel  out  1  latched jogador_alvo; steers addr/we/wdata to P1 or P2 memory.
- mem_we  out  1  write strobe, one cycle.
- mem_wdata  out  DATA_W  write-back word.
- busy  out  1  high from the cycle after start through the DONE state.
- done  out  1  one-cycle result strobe.
- acerto  out  1  hit; valid while done=1, held until next start.
- afundou  out  1  the hit emptied its entry (vessel sunk); valid with done.
- erro  out  1  illegal coordinate; valid with done.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - addr=0, mem_sel=0, mem_we=0, mem_wdata=0.
  - busy=0, done=0, acerto=0, afundou=0, erro=0.
  - Latched linha/coluna cleared.
  - mem_we drops immediately. Because a write lasts exactly one cycle, a reset mid-scan leaves no partial write.
- Slot i of an entry occupies bits [3+8i+7 : 3+8i], i = 0..4, i.e. bits [42:3] overall. Slot value 8'h00 means empty/destroyed cell.
- Bits [63:43] and [2:0] are copied unchanged into mem_wdata.
- State IDLE: on start=1:
  - Latch inputs, then clear acerto, afundou and erro.
  - If linha or coluna is 0 or greater than MAX_COORD: go to DONE with erro=1. No memory access.
  - Otherwise set addr=0 and go to RD.
  - start is ignored in every other state.
- State RD: one cycle for the synchronous memory read, then go to CMP.
- State CMP: compare each slot with {linha, coluna}.
  - On a match in slot i: go to WR. mem_wdata = mem_rdata with slot i forced to 0. If mem_wdata[42:3]==0, set afundou.
  - If several slots match, only the lowest-index slot is cleared.
  - No match and addr==NUM_ENTRADAS-1: go to DONE with acerto=0.
  - No match otherwise: addr=addr+1, go to RD.
- State WR: mem_we=1 for exactly one cycle, with addr held and acerto=1. Then go to DONE. The scan stops at the first hit; coordinates are unique per fleet.
- State DONE: done=1 for one cycle, busy=1, then go to IDLE. Result flags hold until the next accepted start.
- Latency, counting the start-sampling edge as cycle 0:
  - Hit in entry k: WR at cycle 2k+3, done at cycle 2k+4.
  - Miss: done at cycle 25.
  - Illegal coordinate: done at cycle 1.
- Entries that are already all zero are scanned normally and never match, because legal coordinates are nonzero.
- addr never exceeds NUM_ENTRADAS-1. No wrap-around inside a scan.
- A repeat shot on an already-cleared cell is reported as a miss (acerto=0), with no write.

Decomposition:
- Shared package battleship_pkg holds:
  - NUM_ENTRADAS, SLOTS, COORD_W, MAX_COORD.
  - The field-offset constants FIELD_LSB=3 and FIELD_MSB=42.
  - The state encoding (IDLE, RD, CMP, WR, DONE).
  - These offsets are shared with the piece-counting stage.
- One natural sub-module, compara_slots: purely combinational. It takes a word and a coordinate and produces a match flag, the slot index, the cleared word and an empty flag. It is instantiated once in CMP.

Test Plan:
- P2 entry 3 slot 2 = 8'h57, shot linha=5 coluna=7 -> WR at cycle 9 on mem_sel=1, addr=3, mem_wdata has slot 2 = 0 and other bits unchanged; done at cycle 10 with acerto=1, afundou=0.
- P1 entry 0 holds only slot 0 = 8'h11, shot (1,1) -> mem_wdata[42:3]=0, done at cycle 4 with acerto=1, afundou=1.
- Shot (10,10) with no match in any entry -> addrs 0..11 visited, no mem_we, done at cycle 25 with acerto=0.
- Shot (0,4) and shot (11,2) -> done at cycle 1 with erro=1; mem_we never asserted; addr stays 0.
- start pulsed while busy -> ignored; the latched coordinate is unchanged. rst_n=0 in the WR cycle -> mem_we falls asynchronously, busy=0, next start is accepted normally.
- Fire the same hit twice -> second result is acerto=0 with no write; the piece count read afterwards reflects only one clear.
